rst_seq_gen: RTL and testbench

- Staged reset sequencer for testbenches and SoC top levels.
- Sits directly downstream of the clock/reset generator: consumes its clock and raw active-low reset, then releases NumDomains reset outputs one after another at fixed cycle spacing.
- Reports full release and counts cycles since release.
- Supports a software-requested re-reset that reasserts all domains and replays the sequence.

---
 rtl/rst_seq_gen.sv | 101 ++++++++++
 tb/tb_rst_seq_gen.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/rst_seq_gen.sv
// Staged reset sequencer: releases NumDomains active-low resets in index order
// at fixed spacing after raw reset, with software-triggered re-reset and replay.
module rst_seq_gen #(
  parameter int NumDomains   = 3,
  parameter int InitDelay    = 2,
  parameter int StageCycles  = 4,
  parameter int SwHoldCycles = 8,
  parameter int CntWidth     = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  sw_rst_req_i,
  output logic [NumDomains-1:0] rst_no,
  output logic                  all_released_o,
  output logic                  busy_o,
  output logic [CntWidth-1:0]   cycle_cnt_o
);

  localparam logic [2:0] HOLD      = 3'd0;
  localparam logic [2:0] WAIT_INIT = 3'd1;
  localparam logic [2:0] STAGE     = 3'd2;
  localparam logic [2:0] DONE      = 3'd3;
  localparam logic [2:0] SW_HOLD   = 3'd4;

  localparam int MaxA   = (InitDelay > StageCycles) ? InitDelay : StageCycles;
  localparam int MaxDly = (MaxA > SwHoldCycles) ? MaxA : SwHoldCycles;
  localparam int DlyW   = (MaxDly < 2) ? 1 : $clog2(MaxDly);

  // Counters hold "edges remaining minus one", so a load of N-1 fires N edges later.
  localparam logic [DlyW-1:0] InitLd  = DlyW'(InitDelay - 1);
  localparam logic [DlyW-1:0] StageLd = DlyW'(StageCycles - 1);
  localparam logic [DlyW-1:0] SwLd    = DlyW'(SwHoldCycles - 1);

  if (NumDomains < 1)   begin : g_chk_nd $fatal(1, "NumDomains must be >= 1");   end
  if (InitDelay < 1)    begin : g_chk_id $fatal(1, "InitDelay must be >= 1");    end
  if (StageCycles < 1)  begin : g_chk_sc $fatal(1, "StageCycles must be >= 1");  end
  if (SwHoldCycles < 1) begin : g_chk_sh $fatal(1, "SwHoldCycles must be >= 1"); end

  logic [2:0]            state;
  logic [DlyW-1:0]       dly;
  logic [NumDomains-1:0] rst_nxt;

  // Releasing the next domain is a shift-in of a one; all ones means fully released.
  always_comb rst_nxt = (rst_no << 1) | NumDomains'(1);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state          <= HOLD;
      dly            <= '0;
      rst_no         <= '0;
      all_released_o <= 1'b0;
      busy_o         <= 1'b1;
      cycle_cnt_o    <= '0;
    end else begin
      case (state)
        HOLD: begin
          state <= WAIT_INIT;
          dly   <= InitLd;
        end
        WAIT_INIT, STAGE: begin
          if (dly != '0) begin
            dly <= dly - 1'b1;
          end else begin
            rst_no <= rst_nxt;
            dly    <= StageLd;
            if (&rst_nxt) begin
              state          <= DONE;
              all_released_o <= 1'b1;
              busy_o         <= 1'b0;
            end else begin
              state <= STAGE;
            end
          end
        end
        DONE: begin
          if (sw_rst_req_i) begin
            state          <= SW_HOLD;
            dly            <= SwLd;
            rst_no         <= '0;
            all_released_o <= 1'b0;
            busy_o         <= 1'b1;
            cycle_cnt_o    <= '0;
          end else if (cycle_cnt_o != '1) begin
            cycle_cnt_o <= cycle_cnt_o + 1'b1;
          end
        end
        SW_HOLD: begin
          // The final hold edge doubles as E0 of the replayed sequence.
          if (dly != '0) begin
            dly <= dly - 1'b1;
          end else begin
            state <= WAIT_INIT;
            dly   <= InitLd;
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_rst_seq_gen.sv
// Scoreboard bench for rst_seq_gen: two configurations share one randomized stimulus
// stream; a timeline model predicts outputs, a monitor pops and compares each cycle.
module tb_rst_seq_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sw_req = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  a_rst;
  logic        a_all, a_busy;
  logic [31:0] a_cnt;
  logic [0:0]  b_rst;
  logic        b_all, b_busy;
  logic [3:0]  b_cnt;

  rst_seq_gen #(.NumDomains(3), .InitDelay(2), .StageCycles(4), .SwHoldCycles(8), .CntWidth(32)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .sw_rst_req_i(sw_req),
    .rst_no(a_rst), .all_released_o(a_all), .busy_o(a_busy), .cycle_cnt_o(a_cnt));

  rst_seq_gen #(.NumDomains(1), .InitDelay(1), .StageCycles(1), .SwHoldCycles(3), .CntWidth(4)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .sw_rst_req_i(sw_req),
    .rst_no(b_rst), .all_released_o(b_all), .busy_o(b_busy), .cycle_cnt_o(b_cnt));

  typedef struct {
    logic [7:0] rst;
    logic       all;
    logic       busy;
    longint     cnt;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int errors = 0;
  int checks = 0;

  // Timeline model: phase 0 = in raw reset, 1 = sequencing/done (t = edges since E0),
  // 2 = software hold (t = edges since S).
  int     ph[2];
  longint t[2];
  int     nd_p[2] = '{3, 1};
  int     id_p[2] = '{2, 1};
  int     sc_p[2] = '{4, 1};
  int     sh_p[2] = '{8, 3};
  int     cw_p[2] = '{32, 4};

  function automatic exp_t predict(input int i);
    exp_t   e;
    longint full, cmax;
    full  = id_p[i] + (nd_p[i] - 1) * sc_p[i];
    cmax  = (cw_p[i] >= 63) ? 64'h7fff_ffff_ffff_ffff : ((64'sd1 <<< cw_p[i]) - 1);
    e.rst = '0; e.all = 1'b0; e.busy = 1'b1; e.cnt = 0;
    if (ph[i] == 1) begin
      for (int k = 0; k < nd_p[i]; k++)
        e.rst[k] = (t[i] >= id_p[i] + k * sc_p[i]);
      e.all  = (t[i] >= full);
      e.busy = !e.all;
      if (e.all) e.cnt = (t[i] - full > cmax) ? cmax : t[i] - full;
    end
    return e;
  endfunction

  task automatic model_step(input int i, input bit r, input bit s);
    longint full;
    full = id_p[i] + (nd_p[i] - 1) * sc_p[i];
    if (!r) begin
      ph[i] = 0; t[i] = 0;
    end else if (ph[i] == 0) begin
      ph[i] = 1; t[i] = 0;
    end else if (ph[i] == 1) begin
      if (t[i] >= full && s) begin ph[i] = 2; t[i] = 0; end
      else t[i]++;
    end else begin
      t[i]++;
      if (t[i] == sh_p[i]) begin ph[i] = 1; t[i] = 0; end
    end
  endtask

  initial begin
    ph[0] = 0; ph[1] = 0; t[0] = 0; t[1] = 0;
    forever begin
      @(posedge clk);
      model_step(0, rst_n, sw_req);
      model_step(1, rst_n, sw_req);
      q_a.push_back(predict(0));
      q_b.push_back(predict(1));
    end
  end

  task automatic cmp(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      while (q_a.size() > 0) begin
        e = q_a.pop_front();
        cmp("a_rst_no", longint'(a_rst), longint'(e.rst));
        cmp("a_all_released", longint'(a_all), longint'(e.all));
        cmp("a_busy", longint'(a_busy), longint'(e.busy));
        cmp("a_cycle_cnt", longint'(a_cnt), e.cnt);
      end
      while (q_b.size() > 0) begin
        e = q_b.pop_front();
        cmp("b_rst_no", longint'(b_rst), longint'(e.rst));
        cmp("b_all_released", longint'(b_all), longint'(e.all));
        cmp("b_busy", longint'(b_busy), longint'(e.busy));
        cmp("b_cycle_cnt", longint'(b_cnt), e.cnt);
      end
    end
  end

  task automatic drive(input bit r, input bit s, input int n);
    for (int k = 0; k < n; k++) begin
      rst_n  = r;
      sw_req = s;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1;
    // Power-on: 5 reset cycles, then run well into DONE.
    drive(0, 0, 5);
    drive(1, 0, 20);
    // Software re-reset pulse from DONE, then let it replay fully.
    drive(1, 1, 1);
    drive(1, 0, 30);
    // Request mid-sequence is ignored.
    drive(0, 0, 2);
    drive(1, 0, 4);
    drive(1, 1, 1);
    drive(1, 0, 15);
    // Raw reset dropped mid-STAGE, one edge low, then restart.
    drive(0, 0, 1);
    drive(1, 0, 7);
    drive(0, 0, 1);
    drive(1, 0, 25);
    // Request held high continuously: re-triggers each time DONE is reached.
    drive(1, 1, 60);
    // Long DONE hold to exercise counter saturation on the narrow instance.
    drive(1, 0, 40);
    // Randomized tail.
    for (int k = 0; k < 3000; k++)
      drive(($urandom_range(0, 149) != 0), ($urandom_range(0, 19) == 0), 1);
    drive(1, 0, 3);
    @(negedge clk);
    @(negedge clk);
    if (q_a.size() != 0 || q_b.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d/%0d entries left, expected 0", q_a.size(), q_b.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
